mult_product_accumulator: RTL and testbench

Downstream stage of the 8x8 array multiplier (`main`, x/y -> p[15:0]). Takes a stream of 16-bit products p through a valid/ready handshake and sums them into a wide accumulator. Each vector ends with a last-flag beat; the block then presents the sum, beat count and overflow flag and holds them until the consumer accepts. Together with the multiplier it forms a dot-product / MAC datapath.

---
 rtl/mult_product_accumulator.sv | 124 ++++++++++++
 tb/tb_mult_product_accumulator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_product_accumulator.sv
// Sums a stream of unsigned products per vector; result appears one cycle after the last beat.
// p_ready drops while a result is held (until res_ready) and while clear/rst are asserted.
module mult_product_accumulator #(
  parameter int P_W   = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [P_W-1:0]   p,
  input  logic             p_valid,
  input  logic             p_last,
  output logic             p_ready,
  output logic [ACC_W-1:0] res,
  output logic [CNT_W-1:0] res_count,
  output logic             res_ovf,
  output logic             res_valid,
  input  logic             res_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   res_count_q, res_count_d;
  logic               res_ovf_q, res_ovf_d;
  logic               res_valid_q, res_valid_d;

  logic [ACC_W:0]     sum;
  logic               beat_ovf;
  logic [ACC_W-1:0]   new_acc;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;

  always_comb begin
    sum      = {1'b0, acc_q} + (ACC_W+1)'(p);
    beat_ovf = sum[ACC_W];
    if (beat_ovf && (SAT != 0)) new_acc = '1;
    else                        new_acc = sum[ACC_W-1:0];
    // Beat count sticks at its maximum rather than wrapping.
    cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    p_ready  = (state_q != HOLD) && !clear && !rst;
    accept   = p_valid && p_ready;

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_d       = res_q;
    res_count_d = res_count_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;

    if (clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            if (p_last) begin
              res_d       = new_acc;
              res_count_d = cnt_inc;
              res_ovf_d   = ovf_q | beat_ovf;
              res_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_d       = 1'b0;
              state_d     = HOLD;
            end else begin
              acc_d   = new_acc;
              cnt_d   = cnt_inc;
              ovf_d   = ovf_q | beat_ovf;
              state_d = ACCUM;
            end
          end
        end
        HOLD: begin
          if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_q       <= '0;
      res_count_q <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_q       <= res_d;
      res_count_q <= res_count_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res       = res_q;
  assign res_count = res_count_q;
  assign res_ovf   = res_ovf_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Bench for mult_product_accumulator: four parameterisations share one stimulus stream.
module tb_mult_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, p_valid, p_last, res_ready;
  logic [15:0] p;

  logic        rdy0, rdy1, rdy2, rdy3;
  logic [23:0] r0, r3;
  logic [17:0] r1, r2;
  logic [7:0]  c0, c1, c2;
  logic [1:0]  c3;
  logic        o0, o1, o2, o3, v0, v1, v2, v3;

  mult_product_accumulator #(.P_W(16), .ACC_W(24), .CNT_W(8), .SAT(1)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .p(p), .p_valid(p_valid), .p_last(p_last),
    .p_ready(rdy0), .res(r0), .res_count(c0), .res_ovf(o0), .res_valid(v0), .res_ready(res_ready));
  mult_product_accumulator #(.P_W(16), .ACC_W(18), .CNT_W(8), .SAT(1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .p(p), .p_valid(p_valid), .p_last(p_last),
    .p_ready(rdy1), .res(r1), .res_count(c1), .res_ovf(o1), .res_valid(v1), .res_ready(res_ready));
  mult_product_accumulator #(.P_W(16), .ACC_W(18), .CNT_W(8), .SAT(0)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .p(p), .p_valid(p_valid), .p_last(p_last),
    .p_ready(rdy2), .res(r2), .res_count(c2), .res_ovf(o2), .res_valid(v2), .res_ready(res_ready));
  mult_product_accumulator #(.P_W(16), .ACC_W(24), .CNT_W(2), .SAT(1)) u3 (
    .clk(clk), .rst(rst), .clear(clear), .p(p), .p_valid(p_valid), .p_last(p_last),
    .p_ready(rdy3), .res(r3), .res_count(c3), .res_ovf(o3), .res_valid(v3), .res_ready(res_ready));

  localparam int ACCW [4] = '{24, 18, 18, 24};
  localparam int CNTW [4] = '{8, 8, 8, 2};
  localparam int SATV [4] = '{1, 1, 0, 1};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: beats of the open vector, and the result each instance should hold.
  int     m_beats[$];
  bit     m_hold, m_valid;
  longint m_res [4];
  longint m_cnt [4];
  bit     m_ovf [4];

  function automatic void calc(input int k, output longint r, output longint c, output bit o);
    longint acc = 0;
    longint lim = longint'(1) << ACCW[k];
    longint cmax = (longint'(1) << CNTW[k]) - 1;
    o = 1'b0;
    foreach (m_beats[i]) begin
      acc += m_beats[i];
      if (acc >= lim) begin
        o = 1'b1;
        acc = (SATV[k] != 0) ? lim - 1 : acc - lim;
      end
    end
    r = acc;
    c = (m_beats.size() > cmax) ? cmax : longint'(m_beats.size());
  endfunction

  task automatic model_reset();
    m_beats.delete();
    m_hold = 1'b0;
    m_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_res[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    if (rst) model_reset();
    else if (clear) begin
      m_beats.delete();
      m_hold = 1'b0;
      m_valid = 1'b0;
    end else if (m_hold) begin
      if (res_ready) begin m_hold = 1'b0; m_valid = 1'b0; end
    end else if (p_valid) begin
      m_beats.push_back(int'(p));
      if (p_last) begin
        for (int k = 0; k < 4; k++) calc(k, m_res[k], m_cnt[k], m_ovf[k]);
        m_valid = 1'b1;
        m_hold = 1'b1;
        m_beats.delete();
      end
    end
  endtask

  task automatic check_outputs();
    logic [63:0] ar [4];
    logic [63:0] ac [4];
    logic        ad [4];
    logic        av [4];
    logic        ao [4];
    bit          exp_rdy;
    ar[0] = 64'(r0); ar[1] = 64'(r1); ar[2] = 64'(r2); ar[3] = 64'(r3);
    ac[0] = 64'(c0); ac[1] = 64'(c1); ac[2] = 64'(c2); ac[3] = 64'(c3);
    ad[0] = rdy0; ad[1] = rdy1; ad[2] = rdy2; ad[3] = rdy3;
    av[0] = v0; av[1] = v1; av[2] = v2; av[3] = v3;
    ao[0] = o0; ao[1] = o1; ao[2] = o2; ao[3] = o3;
    exp_rdy = !m_hold && !clear && !rst;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("p_ready[%0d]", k), 64'(ad[k]), 64'(exp_rdy));
      chk($sformatf("res_valid[%0d]", k), 64'(av[k]), 64'(m_valid));
      chk($sformatf("res[%0d]", k), ar[k], 64'(m_res[k]));
      chk($sformatf("res_count[%0d]", k), ac[k], 64'(m_cnt[k]));
      chk($sformatf("res_ovf[%0d]", k), 64'(ao[k]), 64'(m_ovf[k]));
    end
  endtask

  // One clock: check at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] val, input logic last);
    p = val; p_valid = 1'b1; p_last = last;
    tick();
    p_valid = 1'b0; p_last = 1'b0; p = '0;
  endtask

  typedef struct {
    logic [15:0] p;
    bit v, l, c, rr;
    bit e_rdy, e_vld;
    int e_res, e_cnt;
    bit e_ovf;
  } vec_t;

  function automatic vec_t mk(input int pv, input bit v, input bit l, input bit c, input bit rr,
                              input bit er, input bit ev, input int eres, input int ecnt, input bit eo);
    vec_t t;
    t.p = 16'(pv); t.v = v; t.l = l; t.c = c; t.rr = rr;
    t.e_rdy = er; t.e_vld = ev; t.e_res = eres; t.e_cnt = ecnt; t.e_ovf = eo;
    return t;
  endfunction

  vec_t tbl [16];

  initial begin
    tbl[0]  = mk(15,    1, 0, 0, 1, 1, 0, 0,      0, 0);
    tbl[1]  = mk(8,     1, 0, 0, 1, 1, 0, 0,      0, 0);
    tbl[2]  = mk(4,     1, 0, 0, 1, 1, 0, 0,      0, 0);
    tbl[3]  = mk(48,    1, 1, 0, 1, 1, 0, 0,      0, 0);
    tbl[4]  = mk(0,     0, 0, 0, 1, 0, 1, 75,     4, 0);
    tbl[5]  = mk(0,     0, 0, 0, 0, 1, 0, 75,     4, 0);
    tbl[6]  = mk(65025, 1, 0, 0, 0, 1, 0, 75,     4, 0);
    tbl[7]  = mk(65025, 1, 0, 0, 0, 1, 0, 75,     4, 0);
    tbl[8]  = mk(65025, 1, 1, 0, 0, 1, 0, 75,     4, 0);
    for (int i = 9; i < 14; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 1, 195075, 3, 0);
    tbl[14] = mk(0,     0, 0, 0, 1, 0, 1, 195075, 3, 0);
    tbl[15] = mk(0,     0, 0, 0, 0, 1, 0, 195075, 3, 0);

    rst = 1'b1; clear = 1'b0; p = '0; p_valid = 1'b0; p_last = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_ready", 64'(rdy0), 64'(0));
    chk("reset_valid", 64'(v0), 64'(0));
    chk("reset_res", 64'(r0), 64'(0));
    chk("reset_count", 64'(c0), 64'(0));
    chk("reset_ovf", 64'(o0), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 64'(rdy0), 64'(1));

    for (int i = 0; i < 16; i++) begin
      p = tbl[i].p; p_valid = tbl[i].v; p_last = tbl[i].l; clear = tbl[i].c; res_ready = tbl[i].rr;
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(rdy0), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_valid", i), 64'(v0), 64'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_res", i), 64'(r0), 64'(tbl[i].e_res));
      chk($sformatf("tbl%0d_count", i), 64'(c0), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_ovf", i), 64'(o0), 64'(tbl[i].e_ovf));
      tick();
    end
    p_valid = 1'b0; p_last = 1'b0; res_ready = 1'b0;

    // Overflow: 5 x 65025 against an 18-bit accumulator, saturating and wrapping.
    for (int i = 0; i < 5; i++) beat(16'd65025, i == 4);
    chk("sat_res", 64'(r1), 64'(262143));
    chk("sat_ovf", 64'(o1), 64'(1));
    chk("wrap_res", 64'(r2), 64'(62981));
    chk("wrap_ovf", 64'(o2), 64'(1));
    chk("wide_res", 64'(r0), 64'(325125));
    chk("wide_ovf", 64'(o0), 64'(0));
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    beat(16'd1, 1'b1);
    chk("after_ovf_res", 64'(r1), 64'(1));
    chk("after_ovf_flag", 64'(o1), 64'(0));
    chk("after_wrap_flag", 64'(o2), 64'(0));
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    // Clear mid-vector with a beat offered.
    beat(16'd100, 1'b0);
    beat(16'd200, 1'b0);
    clear = 1'b1; p_valid = 1'b1; p = 16'd300;
    #1;
    chk("clear_ready", 64'(rdy0), 64'(0));
    tick();
    clear = 1'b0; p_valid = 1'b0;
    beat(16'd7, 1'b1);
    chk("clear_next_res", 64'(r0), 64'(7));
    chk("clear_next_count", 64'(c0), 64'(1));
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    // Reset while a result is held.
    beat(16'd15, 1'b0); beat(16'd8, 1'b0); beat(16'd4, 1'b0); beat(16'd48, 1'b1);
    chk("hold_res", 64'(r0), 64'(75));
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    chk("rst_hold_valid", 64'(v0), 64'(0));
    chk("rst_hold_res", 64'(r0), 64'(0));
    chk("rst_hold_count", 64'(c0), 64'(0));
    chk("rst_hold_ready", 64'(rdy0), 64'(1));

    // Beat counter saturation on the 2-bit instance.
    for (int i = 0; i < 6; i++) beat(16'd1, i == 5);
    chk("cnt_sat_res", 64'(r3), 64'(6));
    chk("cnt_sat_count", 64'(c3), 64'(3));
    chk("cnt_sat_ovf", 64'(o3), 64'(0));
    chk("cnt_wide_count", 64'(c0), 64'(6));
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      p         = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 65535))
                                              : 16'($urandom_range(40000, 65535));
      p_valid   = ($urandom_range(0, 3) != 0);
      p_last    = ($urandom_range(0, 5) == 0);
      clear     = ($urandom_range(0, 60) == 0);
      rst       = ($urandom_range(0, 300) == 0);
      res_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0; clear = 1'b0; p_valid = 1'b0; p_last = 1'b0; res_ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
